// File: rtl/boa_arith_pkg.sv
// Shared types and constants for the sequential restoring divider.
package boa_arith_pkg;

  localparam int unsigned BOA_DIV_W     = 32;
  localparam int unsigned BOA_DIV_ITER  = 32;
  localparam int unsigned BOA_DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } boa_div_state_t;

  // Per-operation context kept alongside the datapath for result correction.
  typedef struct packed {
    logic                 sign_lhs;
    logic                 sign_rhs;
    logic                 div_zero;
    logic [BOA_DIV_W-1:0] lhs;
  } boa_div_ctx_t;

  function automatic logic [BOA_DIV_W-1:0] boa_neg(input logic [BOA_DIV_W-1:0] x);
    return ~x + BOA_DIV_W'(1);
  endfunction

  function automatic logic [BOA_DIV_W-1:0] boa_cond_neg(input logic                 neg,
                                                        input logic [BOA_DIV_W-1:0] x);
    return neg ? boa_neg(x) : x;
  endfunction

endpackage

// File: rtl/boa_div_step.sv
// One radix-2 restoring division iteration on the {rem,quo} pair.
module boa_div_step
  import boa_arith_pkg::*;
(
  input  logic [BOA_DIV_W-1:0] rem,
  input  logic [BOA_DIV_W-1:0] quo,
  input  logic [BOA_DIV_W-1:0] divisor,
  output logic [BOA_DIV_W-1:0] next_rem,
  output logic [BOA_DIV_W-1:0] next_quo
);

  logic [BOA_DIV_W:0]   w_shift;
  logic [BOA_DIV_W-1:0] w_diff;
  logic                 w_ge;

  // The shifted remainder needs one extra bit before the compare.
  assign w_shift = {rem, quo[BOA_DIV_W-1]};
  assign w_ge    = (w_shift >= {1'b0, divisor});
  assign w_diff  = w_shift[BOA_DIV_W-1:0] - divisor;

  assign next_rem = w_ge ? w_diff : w_shift[BOA_DIV_W-1:0];
  assign next_quo = {quo[BOA_DIV_W-2:0], w_ge};

endmodule

// File: rtl/boa_div_seq.sv
// Iterative 32-bit signed/unsigned restoring divider, one quotient bit per clock.
// Optional BOA_DIV_EARLY_EXIT_EN: trivial operations skip CALC and go straight to DONE.
module boa_div_seq
  import boa_arith_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 u,
  input  logic [BOA_DIV_W-1:0] lhs,
  input  logic [BOA_DIV_W-1:0] rhs,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BOA_DIV_W-1:0] div_res,
  output logic [BOA_DIV_W-1:0] mod_res
);

  boa_div_state_t           r_state;
  logic [BOA_DIV_CNT_W-1:0] r_cnt;
  logic [BOA_DIV_W-1:0]     r_rem;
  logic [BOA_DIV_W-1:0]     r_quo;
  logic [BOA_DIV_W-1:0]     r_divisor;
  boa_div_ctx_t             r_ctx;
  logic                     r_in_ready;
  logic                     r_out_valid;

  logic                     w_sign_lhs;
  logic                     w_sign_rhs;
  logic [BOA_DIV_W-1:0]     w_lhs_mag;
  logic [BOA_DIV_W-1:0]     w_rhs_mag;
  logic                     w_div_zero;
  logic                     w_last;
  logic [BOA_DIV_W-1:0]     w_next_rem;
  logic [BOA_DIV_W-1:0]     w_next_quo;
`ifdef BOA_DIV_EARLY_EXIT_EN
  logic                     w_early;
`endif

  assign w_sign_lhs = ~u & lhs[BOA_DIV_W-1];
  assign w_sign_rhs = ~u & rhs[BOA_DIV_W-1];
  assign w_lhs_mag  = boa_cond_neg(w_sign_lhs, lhs);
  assign w_rhs_mag  = boa_cond_neg(w_sign_rhs, rhs);
  assign w_div_zero = (rhs == '0);
  assign w_last     = (r_cnt == BOA_DIV_CNT_W'(BOA_DIV_ITER - 1));
`ifdef BOA_DIV_EARLY_EXIT_EN
  assign w_early    = w_div_zero | (w_lhs_mag < w_rhs_mag);
`endif

  boa_div_step u_step (
    .rem      (r_rem),
    .quo      (r_quo),
    .divisor  (r_divisor),
    .next_rem (w_next_rem),
    .next_quo (w_next_quo)
  );

  // Control and datapath registers; flush wins over any handshake in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_ctx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_ctx.sign_lhs <= w_sign_lhs;
            r_ctx.sign_rhs <= w_sign_rhs;
            r_ctx.div_zero <= w_div_zero;
            r_ctx.lhs      <= lhs;
            r_divisor      <= w_rhs_mag;
            r_cnt          <= '0;
            r_in_ready     <= 1'b0;
`ifdef BOA_DIV_EARLY_EXIT_EN
            if (w_early) begin
              r_rem       <= w_lhs_mag;
              r_quo       <= '0;
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_rem   <= '0;
              r_quo   <= w_lhs_mag;
              r_state <= CALC;
            end
`else
            r_rem   <= '0;
            r_quo   <= w_lhs_mag;
            r_state <= CALC;
`endif
          end
        end
        CALC: begin
          r_rem <= w_next_rem;
          r_quo <= w_next_quo;
          r_cnt <= r_cnt + BOA_DIV_CNT_W'(1);
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;

  // Sign correction straight off the registers; divide-by-zero overrides it.
  assign div_res = r_ctx.div_zero ? '1
                 : boa_cond_neg(r_ctx.sign_lhs ^ r_ctx.sign_rhs, r_quo);
  assign mod_res = r_ctx.div_zero ? r_ctx.lhs
                 : boa_cond_neg(r_ctx.sign_lhs, r_rem);

endmodule

// File: tb/tb_boa_div_seq.sv
// Scoreboard bench for boa_div_seq: directed vectors, backpressure, flush and mid-op reset.
module tb_boa_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        u = 1'b0;
  logic [31:0] lhs = '0;
  logic [31:0] rhs = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] div_res;
  logic [31:0] mod_res;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb_q[$];

`ifdef BOA_DIV_EARLY_EXIT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  boa_div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .u         (u),
    .lhs       (lhs),
    .rhs       (rhs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .div_res   (div_res),
    .mod_res   (mod_res)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every result handshake pops one expected {div,mod} pair.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got %h with empty scoreboard", {div_res, mod_res});
      end else begin
        e = sb_q.pop_front();
        check("result", {div_res, mod_res}, e);
      end
    end
  end

  // Issue one op; latency counted in edges including the accept edge.
  task automatic run_op(input string name, input bit uu, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ediv,
                        input logic [31:0] emod, input bit early);
    int lat;
    int busy_rdy;
    int exp_lat;
    exp_lat  = (EARLY_EN && early) ? 1 : 33;
    busy_rdy = 0;
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    sb_q.push_back({ediv, emod});
    u = uu; lhs = a; rhs = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_rdy++;
      tick();
      lat++;
    end
    if (!out_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got no out_valid after %0d edges, required %0d", name, lat, exp_lat);
    end else begin
      check({name, "_latency"}, 64'(lat), 64'(exp_lat));
      check({name, "_busy_in_ready"}, 64'(busy_rdy), 64'd0);
      check({name, "_done_in_ready"}, 64'(in_ready), 64'd0);
      if (out_ready) begin
        tick();
        check({name, "_idle_after"}, {62'd0, out_valid, in_ready}, 64'd1);
      end
    end
  endtask

  initial begin : stim
    int seen_valid;
    #1 rst_n = 1'b0;
    #1;
    check("reset_outputs", {30'd0, in_ready, out_valid, div_res, mod_res}, {30'd0, 2'b10, 64'd0});
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    run_op("udiv_100_7",   1'b1, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0);
    run_op("sdiv_m7_2",    1'b0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op("sdiv_ovf",     1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0);
    run_op("sdiv_zero",    1'b0, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
    run_op("udiv_zero",    1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1);
    run_op("udiv_0_5",     1'b1, 32'd0,         32'd5,         32'd0,         32'd0,         1'b1);
    run_op("udiv_3_10",    1'b1, 32'd3,         32'd10,        32'd0,         32'd3,         1'b1);
    run_op("udiv_7_7",     1'b1, 32'd7,         32'd7,         32'd1,         32'd0,         1'b0);
    run_op("sdiv_7_m2",    1'b0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0);
    run_op("sdiv_m8_m3",   1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2,         32'hFFFF_FFFE, 1'b0);
    run_op("udiv_max_1",   1'b1, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0);

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    run_op("bp_max_2", 1'b1, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_result", {div_res, mod_res}, {32'h7FFF_FFFF, 32'd1});
      check("bp_hold_flags", {62'd0, out_valid, in_ready}, 64'd2);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_idle_after", {62'd0, out_valid, in_ready}, 64'd1);

    // Flush at iteration 10 with a competing operation offered in that cycle.
    check("flush_pre_in_ready", 64'(in_ready), 64'd1);
    u = 1'b1; lhs = 32'd100; rhs = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1; in_valid = 1'b1; lhs = 32'd50; rhs = 32'd5;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_state", {62'd0, out_valid, in_ready}, 64'd1);
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen_valid++;
      tick();
    end
    check("flush_no_valid", 64'(seen_valid), 64'd0);
    run_op("after_flush_9_3", 1'b1, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // Asynchronous reset in the middle of CALC.
    u = 1'b1; lhs = 32'd100; rhs = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("midop_reset", {30'd0, in_ready, out_valid, div_res, mod_res}, {30'd0, 2'b10, 64'd0});
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_op("after_reset_100_7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    repeat (3) tick();
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
